// File: rtl/rca_pkg.sv
// Shared types and constants for the RCA issue controller and its grid tracker.
package rca_pkg;

  localparam int unsigned NUM_GRIDS_DEF = 4;
  localparam int unsigned CFG_W_DEF     = 4;

  localparam logic [6:0] RCA_OPCODE    = 7'b0101011;
  localparam logic [2:0] FUNCT3_USE    = 3'b000;
  localparam logic [2:0] FUNCT3_CONFIG = 3'b001;

  typedef enum logic [1:0] {
    WbOk            = 2'b00,
    WbNotConfigured = 2'b01,
    WbReconfErr     = 2'b10,
    WbTimeout       = 2'b11
  } rca_wb_status_t;

  typedef enum logic [2:0] {
    StIdle,
    StUseDispatch,
    StCfgDrain,
    StCfgReq,
    StCfgWait,
    StWb
  } rca_ctrl_state_t;

endpackage

// File: rtl/rca_grid_tracker.sv
// Per-grid loaded flag, loaded configuration ID and outstanding-use counter.
module rca_grid_tracker import rca_pkg::*; #(
  parameter int unsigned NUM_GRIDS       = NUM_GRIDS_DEF,
  parameter int unsigned CFG_W           = CFG_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned GW             = $clog2(NUM_GRIDS),
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             inc,
  input  logic [GW-1:0]                    inc_grid,
  input  logic                             dec,
  input  logic [GW-1:0]                    dec_grid,
  input  logic                             load_set,
  input  logic                             load_clr,
  input  logic [GW-1:0]                    load_grid,
  input  logic [CFG_W-1:0]                 load_cfg,
  output logic [NUM_GRIDS-1:0]             loaded,
  output logic [NUM_GRIDS-1:0][CFG_W-1:0]  cfg_ids,
  output logic [NUM_GRIDS-1:0][CNT_W-1:0]  counts
);

  logic [NUM_GRIDS-1:0]            loaded_q, loaded_d;
  logic [NUM_GRIDS-1:0][CFG_W-1:0] cfg_q, cfg_d;
  logic [NUM_GRIDS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_GRIDS-1:0]            inc_hit, dec_hit;

  always_comb begin
    inc_hit  = '0;
    dec_hit  = '0;
    loaded_d = loaded_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    if (inc) inc_hit[inc_grid] = 1'b1;
    if (dec) dec_hit[dec_grid] = 1'b1;
    for (int unsigned g = 0; g < NUM_GRIDS; g++) begin
      // A complete against an empty counter is dropped; inc+dec together cancel.
      case ({inc_hit[g], dec_hit[g] && (cnt_q[g] != '0)})
        2'b10:   cnt_d[g] = cnt_q[g] + CNT_W'(1);
        2'b01:   cnt_d[g] = cnt_q[g] - CNT_W'(1);
        default: cnt_d[g] = cnt_q[g];
      endcase
    end
    if (load_clr) loaded_d[load_grid] = 1'b0;
    if (load_set) begin
      loaded_d[load_grid] = 1'b1;
      cfg_d[load_grid]    = load_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= '0;
      cfg_q    <= '0;
      cnt_q    <= '0;
    end else begin
      loaded_q <= loaded_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign loaded  = loaded_q;
  assign cfg_ids = cfg_q;
  assign counts  = cnt_q;

endmodule

// File: rtl/rca_issue_controller.sv
// Sequences RCA use/config instructions to the grids and reconfiguration port,
// producing one writeback record per accepted instruction.
module rca_issue_controller import rca_pkg::*; #(
  parameter int unsigned NUM_GRIDS       = NUM_GRIDS_DEF,
  parameter int unsigned CFG_W           = CFG_W_DEF,
  parameter int unsigned ID_W            = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned GW             = $clog2(NUM_GRIDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic                 issue_is_config,
  input  logic [GW-1:0]        issue_grid,
  input  logic [CFG_W-1:0]     issue_cfg_id,
  input  logic [ID_W-1:0]      issue_id,
  output logic                 use_valid,
  output logic [GW-1:0]        use_grid,
  output logic [ID_W-1:0]      use_id,
  input  logic                 use_ready,
  input  logic                 use_complete,
  input  logic [GW-1:0]        use_complete_grid,
  output logic                 reconf_req,
  output logic [GW-1:0]        reconf_grid,
  output logic [CFG_W-1:0]     reconf_cfg_id,
  input  logic                 reconf_done,
  input  logic                 reconf_err,
  output logic                 wb_valid,
  output logic [ID_W-1:0]      wb_id,
  output logic [1:0]           wb_status,
  input  logic                 wb_ack,
  output logic [NUM_GRIDS-1:0] grid_loaded
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  rca_ctrl_state_t state_q, state_d;
  rca_wb_status_t  status_q, status_d;
  logic [GW-1:0]    grid_q, grid_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic                            trk_inc, trk_set, trk_clr;
  logic [GW-1:0]                   trk_load_grid;
  logic [NUM_GRIDS-1:0][CFG_W-1:0] cfg_ids;
  logic [NUM_GRIDS-1:0][CNT_W-1:0] counts;

  rca_grid_tracker #(
    .NUM_GRIDS       (NUM_GRIDS),
    .CFG_W           (CFG_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .inc       (trk_inc),
    .inc_grid  (grid_q),
    .dec       (use_complete),
    .dec_grid  (use_complete_grid),
    .load_set  (trk_set),
    .load_clr  (trk_clr),
    .load_grid (trk_load_grid),
    .load_cfg  (cfg_q),
    .loaded    (grid_loaded),
    .cfg_ids   (cfg_ids),
    .counts    (counts)
  );

  // The clear happens on acceptance, before grid_q holds the new target.
  assign trk_load_grid = trk_clr ? issue_grid : grid_q;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    grid_d      = grid_q;
    cfg_d       = cfg_q;
    id_d        = id_q;
    tmo_d       = tmo_q;
    issue_ready = 1'b0;
    use_valid   = 1'b0;
    reconf_req  = 1'b0;
    wb_valid    = 1'b0;
    trk_inc     = 1'b0;
    trk_set     = 1'b0;
    trk_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        issue_ready = !rst;
        if (issue_valid && issue_ready) begin
          grid_d = issue_grid;
          cfg_d  = issue_cfg_id;
          id_d   = issue_id;
          if (!issue_is_config) begin
            if (!grid_loaded[issue_grid]) begin
              status_d = WbNotConfigured;
              state_d  = StWb;
            end else begin
              state_d = StUseDispatch;
            end
          end else if (grid_loaded[issue_grid] && (cfg_ids[issue_grid] == issue_cfg_id)) begin
            status_d = WbOk;
            state_d  = StWb;
          end else begin
            trk_clr = 1'b1;
            state_d = StCfgDrain;
          end
        end
      end
      StUseDispatch: begin
        use_valid = counts[grid_q] < CNT_W'(MAX_OUTSTANDING);
        if (use_valid && use_ready) begin
          trk_inc  = 1'b1;
          status_d = WbOk;
          state_d  = StWb;
        end
      end
      StCfgDrain: begin
        if (counts[grid_q] == '0) state_d = StCfgReq;
      end
      StCfgReq: begin
        reconf_req = 1'b1;
        tmo_d      = '0;
        state_d    = StCfgWait;
      end
      StCfgWait: begin
        reconf_req = 1'b1;
        if (reconf_done) begin
          trk_set  = 1'b1;
          status_d = WbOk;
          state_d  = StWb;
        end else if (reconf_err) begin
          status_d = WbReconfErr;
          state_d  = StWb;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          status_d = WbTimeout;
          state_d  = StWb;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StWb: begin
        wb_valid = 1'b1;
        if (wb_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      status_q <= WbOk;
      grid_q   <= '0;
      cfg_q    <= '0;
      id_q     <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      grid_q   <= grid_d;
      cfg_q    <= cfg_d;
      id_q     <= id_d;
      tmo_q    <= tmo_d;
    end
  end

  assign use_grid      = use_valid  ? grid_q   : '0;
  assign use_id        = use_valid  ? id_q     : '0;
  assign reconf_grid   = reconf_req ? grid_q   : '0;
  assign reconf_cfg_id = reconf_req ? cfg_q    : '0;
  assign wb_id         = wb_valid   ? id_q     : '0;
  assign wb_status     = wb_valid   ? status_q : WbOk;

endmodule

// File: tb/tb_rca_issue_controller.sv
// Scoreboard bench for rca_issue_controller: expected writeback records are
// queued at issue time and compared when the controller retires them.
module tb_rca_issue_controller;
  import rca_pkg::*;

  logic       clk, rst;
  logic       issue_valid, issue_ready, issue_is_config;
  logic [1:0] issue_grid;
  logic [3:0] issue_cfg_id;
  logic [2:0] issue_id;
  logic       use_valid, use_ready, use_complete;
  logic [1:0] use_grid, use_complete_grid;
  logic [2:0] use_id;
  logic       reconf_req, reconf_done, reconf_err;
  logic [1:0] reconf_grid;
  logic [3:0] reconf_cfg_id;
  logic       wb_valid, wb_ack;
  logic [2:0] wb_id;
  logic [1:0] wb_status;
  logic [3:0] grid_loaded;

  rca_issue_controller dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_is_config   (issue_is_config),
    .issue_grid        (issue_grid),
    .issue_cfg_id      (issue_cfg_id),
    .issue_id          (issue_id),
    .use_valid         (use_valid),
    .use_grid          (use_grid),
    .use_id            (use_id),
    .use_ready         (use_ready),
    .use_complete      (use_complete),
    .use_complete_grid (use_complete_grid),
    .reconf_req        (reconf_req),
    .reconf_grid       (reconf_grid),
    .reconf_cfg_id     (reconf_cfg_id),
    .reconf_done       (reconf_done),
    .reconf_err        (reconf_err),
    .wb_valid          (wb_valid),
    .wb_id             (wb_id),
    .wb_status         (wb_status),
    .wb_ack            (wb_ack),
    .grid_loaded       (grid_loaded)
  );

  typedef struct packed {
    logic [2:0] id;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_disp   = 0;
  int   n_req_cyc = 0;
  int   mdl_cnt[4];
  int   snap;
  int   n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!issue_ready && k < 200) begin
      tick();
      k++;
    end
    check(tag, issue_ready, 1);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!reconf_req && k < 200) begin
      tick();
      k++;
    end
    check(tag, reconf_req, 1);
  endtask

  task automatic do_issue(input logic cfg, input logic [1:0] g, input logic [3:0] c,
                          input logic [2:0] id, input logic [1:0] exp_st);
    wait_idle("issue_ready_wait");
    issue_valid     = 1'b1;
    issue_is_config = cfg;
    issue_grid      = g;
    issue_cfg_id    = c;
    issue_id        = id;
    sb_q.push_back('{id: id, st: exp_st});
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic complete(input logic [1:0] g);
    use_complete      = 1'b1;
    use_complete_grid = g;
    tick();
    use_complete = 1'b0;
  endtask

  // Retire-side monitor: scoreboard compare, dispatch/request accounting.
  always @(negedge clk) begin
    if (rst) begin
      for (int g = 0; g < 4; g++) mdl_cnt[g] = 0;
    end else begin
      if (use_complete) begin
        if (mdl_cnt[use_complete_grid] == 0) $error("use_complete on grid with no outstanding op");
        else mdl_cnt[use_complete_grid]--;
      end
      if (use_valid && use_ready) begin
        n_disp++;
        mdl_cnt[use_grid]++;
      end
      if (reconf_req) n_req_cyc++;
      if (wb_valid && wb_ack) begin
        if (sb_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_id", wb_id, mon_e.id);
          check("wb_status", wb_status, mon_e.st);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_is_config = 1'b0; issue_grid = '0; issue_cfg_id = '0;
    issue_id = '0; use_ready = 1'b1; use_complete = 1'b0; use_complete_grid = '0;
    reconf_done = 1'b0; reconf_err = 1'b0; wb_ack = 1'b1;
    repeat (3) tick();
    check("rst_issue_ready", issue_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_use_valid", use_valid, 0);
    check("rst_reconf_req", reconf_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_grid_loaded", grid_loaded, 4'b0000);
    check("rst_issue_ready_rel", issue_ready, 1);

    // 1: USE on an unloaded grid, with writeback held off for a few cycles.
    wb_ack = 1'b0;
    do_issue(1'b0, 2'd2, 4'd0, 3'd1, WbNotConfigured);
    check("t1_wb_valid", wb_valid, 1);
    check("t1_wb_status", wb_status, 2'b01);
    repeat (3) tick();
    check("t1_wb_hold", wb_valid, 1);
    check("t1_not_ready", issue_ready, 0);
    wb_ack = 1'b1;
    tick();
    check("t1_ready_after_ack", issue_ready, 1);
    check("t1_no_dispatch", n_disp, 0);

    // 2: CONFIG grid 1 cfg 5, then the same config again is skipped.
    do_issue(1'b1, 2'd1, 4'd5, 3'd2, WbOk);
    wait_req("t2_req");
    check("t2_req_grid", reconf_grid, 2'd1);
    check("t2_req_cfg", reconf_cfg_id, 4'd5);
    repeat (10) tick();
    check("t2_req_hold", reconf_req, 1);
    reconf_done = 1'b1;
    tick();
    reconf_done = 1'b0;
    check("t2_wb_valid", wb_valid, 1);
    check("t2_loaded", grid_loaded, 4'b0010);
    wait_idle("t2_idle");
    snap = n_req_cyc;
    do_issue(1'b1, 2'd1, 4'd5, 3'd3, WbOk);
    check("t2_skip_wb", wb_valid, 1);
    wait_idle("t2_skip_idle");
    check("t2_skip_no_req", n_req_cyc - snap, 0);

    // 3: fill grid 0 to MAX_OUTSTANDING, fifth use stalls until a complete.
    do_issue(1'b1, 2'd0, 4'd3, 3'd4, WbOk);
    wait_req("t3_req");
    tick();
    reconf_done = 1'b1;
    tick();
    reconf_done = 1'b0;
    wait_idle("t3_cfg_idle");
    for (int i = 0; i < 4; i++) begin
      do_issue(1'b0, 2'd0, 4'd0, 3'(i), WbOk);
      wait_idle("t3_use_idle");
    end
    check("t3_four_disp", n_disp, 4);
    do_issue(1'b0, 2'd0, 4'd0, 3'd5, WbOk);
    for (int i = 0; i < 4; i++) begin
      check("t3_stall", use_valid, 0);
      tick();
    end
    use_complete = 1'b1;
    use_complete_grid = 2'd0;
    check("t3_stall_on_complete", use_valid, 0);
    tick();
    use_complete = 1'b0;
    check("t3_resume", use_valid, 1);
    check("t3_use_id", use_id, 3'd5);
    tick();
    check("t3_wb_after_disp", wb_valid, 1);
    wait_idle("t3_idle");
    check("t3_five_disp", n_disp, 5);

    // 4: reconfigure grid 3 while two uses are outstanding.
    do_issue(1'b1, 2'd3, 4'd2, 3'd6, WbOk);
    wait_req("t4_req0");
    tick();
    reconf_done = 1'b1;
    tick();
    reconf_done = 1'b0;
    wait_idle("t4_idle0");
    do_issue(1'b0, 2'd3, 4'd0, 3'd7, WbOk);
    do_issue(1'b0, 2'd3, 4'd0, 3'd0, WbOk);
    do_issue(1'b1, 2'd3, 4'd7, 3'd1, WbOk);
    check("t4_unloaded", grid_loaded[3], 0);
    for (int i = 0; i < 3; i++) begin
      check("t4_drain_hold", reconf_req, 0);
      tick();
    end
    complete(2'd3);
    for (int i = 0; i < 3; i++) begin
      check("t4_drain_hold1", reconf_req, 0);
      tick();
    end
    complete(2'd3);
    check("t4_drain_last", reconf_req, 0);
    tick();
    check("t4_req", reconf_req, 1);
    check("t4_req_cfg", reconf_cfg_id, 4'd7);
    tick();
    reconf_done = 1'b1;
    tick();
    reconf_done = 1'b0;
    wait_idle("t4_idle1");
    check("t4_loaded", grid_loaded[3], 1);

    // 5: timeout length, error response, and done+err together.
    do_issue(1'b1, 2'd2, 4'd9, 3'd2, WbTimeout);
    wait_req("t5_req");
    n = 1;
    while (reconf_req && n < 3000) begin
      tick();
      if (reconf_req) n++;
    end
    check("t5_req_cycles", n, 1025);
    check("t5_wb_valid", wb_valid, 1);
    check("t5_wb_status", wb_status, 2'b11);
    check("t5_unloaded", grid_loaded[2], 0);
    wait_idle("t5_idle0");
    do_issue(1'b1, 2'd2, 4'd4, 3'd3, WbReconfErr);
    wait_req("t5_req_err");
    tick();
    reconf_err = 1'b1;
    tick();
    reconf_err = 1'b0;
    check("t5_err_unloaded", grid_loaded[2], 0);
    wait_idle("t5_idle1");
    do_issue(1'b1, 2'd2, 4'd9, 3'd4, WbOk);
    wait_req("t5_req_both");
    repeat (3) tick();
    reconf_done = 1'b1;
    reconf_err  = 1'b1;
    tick();
    reconf_done = 1'b0;
    reconf_err  = 1'b0;
    check("t5_both_status", wb_status, 2'b00);
    check("t5_both_loaded", grid_loaded[2], 1);
    wait_idle("t5_idle2");

    // 6: reset in the middle of a reconfiguration.
    do_issue(1'b1, 2'd1, 4'd6, 3'd5, WbOk);
    sb_q.delete(sb_q.size() - 1);
    wait_req("t6_req");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t6_req_drop", reconf_req, 0);
    check("t6_loaded", grid_loaded, 4'b0000);
    check("t6_no_wb", wb_valid, 0);
    check("t6_ready_in_rst", issue_ready, 0);
    rst = 1'b0;
    #1;
    check("t6_ready_rel", issue_ready, 1);
    repeat (3) tick();
    check("t6_no_wb_late", wb_valid, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
